// File: rtl/draw_background_scroll.sv
// Background stage: registers VGA timing by one pclk and paints vertically scrolling two-colour bands.
// Optional LFSR starfield is built when DRAW_BACKGROUND_STARS_EN is defined.
module draw_background_scroll #(
  parameter int          CW         = 11,
  parameter int          RGB_W      = 12,
  parameter int          BAND_LOG2  = 4,
  parameter int          SCROLL_DIV = 2,
  parameter logic [11:0] COLOR_A    = 12'h1_1_3,
  parameter logic [11:0] COLOR_B    = 12'h2_2_5,
  parameter logic [11:0] STAR_COLOR = 12'hF_F_F,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             scroll_en,
  input  logic [CW-1:0]    vcount_in,
  input  logic [CW-1:0]    hcount_in,
  input  logic             vsync_in,
  input  logic             vblnk_in,
  input  logic             hsync_in,
  input  logic             hblnk_in,
  output logic [CW-1:0]    vcount_out,
  output logic [CW-1:0]    hcount_out,
  output logic             vsync_out,
  output logic             vblnk_out,
  output logic             hsync_out,
  output logic             hblnk_out,
  output logic [RGB_W-1:0] rgb_out,
  output logic [CW-1:0]    offset_out
);

  localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);

  logic             vblnk_q;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [CW-1:0]    offset_q, offset_d;
  logic             frame_edge;
  logic             blank;
  logic [CW-1:0]    line;
  logic [RGB_W-1:0] rgb_d;

  assign frame_edge = vblnk_in & ~vblnk_q;
  assign blank      = hblnk_in | vblnk_in;
  assign line       = vcount_in + offset_q;
  assign offset_out = offset_q;

  // Frame edges seen while scroll_en is low are simply dropped.
  always_comb begin
    div_cnt_d = div_cnt_q;
    offset_d  = offset_q;
    if (frame_edge && scroll_en) begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
        offset_d  = offset_q + 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vblnk_q   <= 1'b0;
      div_cnt_q <= '0;
      offset_q  <= '0;
    end else begin
      vblnk_q   <= vblnk_in;
      div_cnt_q <= div_cnt_d;
      offset_q  <= offset_d;
    end
  end

`ifdef DRAW_BACKGROUND_STARS_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        star;

  // Reseeding from the scrolled line every blanking cycle ties stars to the bands.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    if (blank) begin
      lfsr_d = (SEED ^ 16'(line)) | 16'h0001;
    end
  end

  assign star = ~blank & (lfsr_q[7:0] == 8'hFF);

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  always_comb begin
    rgb_d = '0;
    if (!blank) begin
      rgb_d = line[BAND_LOG2] ? RGB_W'(COLOR_B) : RGB_W'(COLOR_A);
      if (star) begin
        rgb_d = RGB_W'(STAR_COLOR);
      end
    end
  end
`else
  always_comb begin
    rgb_d = '0;
    if (!blank) begin
      rgb_d = line[BAND_LOG2] ? RGB_W'(COLOR_B) : RGB_W'(COLOR_A);
    end
  end
`endif

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vcount_out <= '0;
      hcount_out <= '0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      vcount_out <= vcount_in;
      hcount_out <= hcount_in;
      vsync_out  <= vsync_in;
      vblnk_out  <= vblnk_in;
      hsync_out  <= hsync_in;
      hblnk_out  <= hblnk_in;
      rgb_out    <= rgb_d;
    end
  end

endmodule

// File: tb/tb_draw_background_scroll.sv
// Directed bench for draw_background_scroll with a cycle-accurate reference model and scoreboard.
module tb_draw_background_scroll;
  localparam int          CW    = 11;
  localparam logic [11:0] CA    = 12'h113;
  localparam logic [11:0] CB    = 12'h225;
  localparam logic [11:0] STARC = 12'hFFF;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic          pclk = 1'b0;
  logic          rst = 1'b0;
  logic          scroll_en = 1'b0;
  logic [CW-1:0] vcount_in = '0, hcount_in = '0;
  logic          vsync_in = 1'b0, vblnk_in = 1'b0, hsync_in = 1'b0, hblnk_in = 1'b0;
  logic [CW-1:0] vcount_out, hcount_out, offset_out;
  logic          vsync_out, vblnk_out, hsync_out, hblnk_out;
  logic [11:0]   rgb_out;

  draw_background_scroll dut (
    .pclk(pclk), .rst(rst), .scroll_en(scroll_en),
    .vcount_in(vcount_in), .hcount_in(hcount_in),
    .vsync_in(vsync_in), .vblnk_in(vblnk_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_out(vcount_out), .hcount_out(hcount_out),
    .vsync_out(vsync_out), .vblnk_out(vblnk_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .rgb_out(rgb_out), .offset_out(offset_out)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [CW-1:0] vc;
    logic [CW-1:0] hc;
    logic          vs, vb, hs, hb;
    logic [11:0]   rgb;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  bit            verbose = 1'b1;
  int            m_div;
  logic [CW-1:0] m_off;
  logic          m_vbq;
  logic [15:0]   m_lfsr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_div  = 0;
    m_off  = '0;
    m_vbq  = 1'b0;
    m_lfsr = SEED;
    sb.delete();
  endtask

  function automatic logic [11:0] model_rgb(input logic hb, input logic vb, input logic [CW-1:0] v);
    logic [CW-1:0] line;
    logic [11:0]   c;
    line = v + m_off;
    if (hb | vb) return 12'h000;
    c = line[4] ? CB : CA;
`ifdef DRAW_BACKGROUND_STARS_EN
    if (m_lfsr[7:0] == 8'hFF) c = STARC;
`endif
    return c;
  endfunction

  // Drive one pixel, advance the model across the edge, then check the DUT output.
  task automatic cycle(input logic [CW-1:0] v, input logic [CW-1:0] h,
                       input logic vs, input logic vb, input logic hs, input logic hb);
    exp_t          e;
    logic [CW-1:0] line;
    vcount_in = v; hcount_in = h; vsync_in = vs; vblnk_in = vb; hsync_in = hs; hblnk_in = hb;
    e.vc = v; e.hc = h; e.vs = vs; e.vb = vb; e.hs = hs; e.hb = hb;
    e.rgb = model_rgb(hb, vb, v);
    sb.push_back(e);
    line = v + m_off;
    @(posedge pclk);
    if (hb | vb) m_lfsr = (SEED ^ {5'b0, line}) | 16'h0001;
    else         m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    if (vb && !m_vbq && scroll_en) begin
      if (m_div == 1) begin m_div = 0; m_off = m_off + 1'b1; end
      else m_div = m_div + 1;
    end
    m_vbq = vb;
    #1;
    e = sb.pop_front();
    chk("vcount", 32'(vcount_out), 32'(e.vc));
    chk("hcount", 32'(hcount_out), 32'(e.hc));
    chk("strobes", {28'd0, vsync_out, vblnk_out, hsync_out, hblnk_out}, {28'd0, e.vs, e.vb, e.hs, e.hb});
    chk("rgb", 32'(rgb_out), 32'(e.rgb));
    chk("offset", 32'(offset_out), 32'(m_off));
    if (verbose)
      $display("txn v=%0d h=%0d vb=%0b hb=%0b rgb=%h off=%0d", v, h, vb, hb, rgb_out, offset_out);
  endtask

  task automatic frame();
    cycle('0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic px(input string tag, input logic [CW-1:0] v, input logic [11:0] expc);
    cycle(v, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(v, 11'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk(tag, 32'(rgb_out), 32'(expc));
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {vcount_out, hcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out},
        {(2*CW+4){1'b0}});
    chk({tag, "_rgb"}, 32'(rgb_out), 32'd0);
    chk({tag, "_off"}, 32'(offset_out), 32'd0);
  endtask

`ifdef DRAW_BACKGROUND_STARS_EN
  task automatic star_line(input logic [CW-1:0] v, output logic [511:0] mask);
    mask = '0;
    cycle(v, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 512; i++) begin
      cycle(v, 11'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      mask[i] = (rgb_out === STARC);
    end
  endtask
`endif

  logic [CW-1:0] saved;
  int            tbl[6] = '{0, 1, 1, 2, 2, 3};

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #1 chk_all_zero("reset_init");
    @(posedge pclk);
    #1 rst = 1'b0;

    scroll_en = 1'b1;
    for (int i = 0; i < 6; i++) frame();
    for (int i = 0; i < 3; i++) cycle(11'd5, 11'(i + 10), 1'b1, 1'b0, 1'b1, 1'b0);
    #3 rst = 1'b1;
    #1 chk_all_zero("reset_async");
    @(posedge pclk);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) cycle(11'd3, 11'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_release_off", 32'(offset_out), 32'd0);

    px("band_v15", 11'd15, CA);
    px("band_v16", 11'd16, CB);
    px("band_v32", 11'd32, CA);

    for (int i = 0; i < 40; i++) begin
      cycle(11'($urandom), 11'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if (hblnk_out | vblnk_out) chk("blank_rgb", 32'(rgb_out), 32'd0);
    end

    cycle('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge pclk);
    #1 rst = 1'b0;
    model_reset();
    sb.delete();
    for (int i = 0; i < 6; i++) begin
      frame();
      chk("scroll_seq", 32'(offset_out), 32'(tbl[i]));
      if (i == 1) px("band_off1_v15", 11'd15, CB);
    end

    scroll_en = 1'b0;
    saved = m_off;
    for (int i = 0; i < 3; i++) frame();
    chk("hold", 32'(offset_out), 32'(saved));

    scroll_en = 1'b1;
    verbose = 1'b0;
    while (m_off != 11'd2047) frame();
    verbose = 1'b1;
    chk("reach_max", 32'(offset_out), 32'd2047);
    px("wrap_line0", 11'd1, CA);
    px("wrap_line16", 11'd17, CB);
    frame();
    frame();
    chk("wrap", 32'(offset_out), 32'd0);

`ifdef DRAW_BACKGROUND_STARS_EN
    begin
      logic [511:0] m1, m2;
      star_line(11'd40, m1);
      frame();
      frame();
      star_line(11'd39, m2);
      chk("stars_repeat", 32'(m1 == m2), 32'd1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/draw_background_scroll.md
# draw_background_scroll

Parametrised successor to the fixed-grey background stage. It sits directly after the VGA timing generator and ahead of the sprite/overlay stages. It forwards all timing signals with one cycle of latency and paints two-colour horizontal bands that scroll vertically at a programmable frame rate. An optional LFSR starfield scrolls with the bands. It also exports the current scroll offset so that later stages can lock to it.

## Interface
Parameters:
- `CW`, 11: width of hcount/vcount and of the scroll offset.
- `RGB_W`, 12: colour word width.
- `BAND_LOG2`, 4: band height is 2^BAND_LOG2 lines.
- `SCROLL_DIV`, 2: frames per one-line scroll step, ≥1.
- `COLOR_A`, 12'h1_1_3: even-band colour.
- `COLOR_B`, 12'h2_2_5: odd-band colour.
- `STAR_COLOR`, 12'hF_F_F: star pixel colour (STARS_EN only).
- `SEED`, 16'hACE1: LFSR base seed (STARS_EN only).

Ports:
- `pclk`, in, 1: pixel clock. Single clock domain.
- `rst`, in, 1: reset, asynchronous and active-high.
- `scroll_en`, in, 1: when 1, the frame divider advances.
- `vcount_in`, `hcount_in`, in, CW: timing counters.
- `vsync_in`, `vblnk_in`, `hsync_in`, `hblnk_in`, in, 1: timing strobes.
- `vcount_out`, `hcount_out`, out, CW: registered copies of the inputs.
- `vsync_out`, `vblnk_out`, `hsync_out`, `hblnk_out`, out, 1: registered copies of the inputs.
- `rgb_out`, out, RGB_W: pixel colour.
- `offset_out`, out, CW: current scroll offset.

## Operation
Reset (async, rst=1):
- All outputs are 0.
- `vblnk_q` = 0, `div_cnt` = 0, `offset` = 0, `lfsr` = SEED.

Pass-through:
- Every timing input is registered once, unchanged.

Frame edge:
- `frame_edge` = vblnk_in & ~vblnk_q. `vblnk_q` is registered every cycle.
- If vblnk_in is already 1 on the first cycle after reset, that cycle counts as a frame edge.

Divider and offset:
- On frame_edge with scroll_en=1: if div_cnt == SCROLL_DIV-1, div_cnt←0 and offset←offset+1 (mod 2^CW, wraps 2^CW-1→0). Otherwise div_cnt←div_cnt+1.
- With scroll_en=0, div_cnt and offset hold.
- There is no edge memory: a frame edge that occurs while scroll_en=0 is lost.
- SCROLL_DIV=1 steps the offset every frame.

Colour, evaluated combinationally from the current-cycle inputs and registered into rgb_out:
- If hblnk_in | vblnk_in: 0.
- Otherwise, let line = (vcount_in + offset) mod 2^CW. Use COLOR_B when line[BAND_LOG2]=1, else COLOR_A.
- With STARS_EN, STAR_COLOR overrides the band colour when a star condition holds (see Configuration).
- The offset used is the registered value. Offset changes happen only at a frame edge, inside blanking, so no visible frame tears.

## Timing
- Latency: exactly 1 pclk from any input to the corresponding output. Within one cycle, rgb_out is aligned with hcount_out/vcount_out.
- offset_out is the registered offset. It updates on the pclk edge that samples frame_edge.
- Reset asserted mid-frame clears everything immediately. The first frame edge after release restarts the divider from 0.
- Throughput: one pixel per pclk, with no stalls.

## Configuration
- `DRAW_BACKGROUND_STARS_EN` defined:
  - 16-bit Galois LFSR, right shift, tap mask 16'hB400.
  - While hblnk_in | vblnk_in, lfsr loads (SEED ^ zero-extended line) | 16'h0001 every cycle, so the last load in a line's blanking uses the new line's vcount.
  - During active video, lfsr steps once per pclk.
  - Star condition: active video and lfsr[7:0] == 8'hFF, evaluated on the pre-step value.
  - Because each line reseeds, stars move with the scroll offset.
- Undefined: no LFSR or star logic is synthesised, and the output is bands only.

## Test plan
- **Reset:** assert rst asynchronously mid-line → all outputs, including offset_out, go to 0 immediately, without waiting for a pclk edge. After release with vblnk_in=0, offset_out stays 0.
- **Pass-through:** random timing inputs → each output equals its input one cycle later. rgb_out is 0 whenever the delayed hblnk_out or vblnk_out is 1.
- **Bands:** offset=0, BAND_LOG2=4, vcount_in=15 → COLOR_A. vcount_in=16 → COLOR_B. vcount_in=32 → COLOR_A.
- **Scroll:** SCROLL_DIV=2, scroll_en=1, 6 frames → offset_out sequence 0,1,1,2,2,3 after each frame edge. With offset=1, vcount_in=15 yields COLOR_B.
- **Hold and wrap:**
  - scroll_en=0 for 3 frames → offset unchanged.
  - Force offset to 2^CW-1 (2047), then one step → 0.
  - With offset=2047 and vcount_in=1, line = 0.
- **Stars (STARS_EN):** two frames with identical (vcount+offset) → identical star pixel positions. Compare them against the reference LFSR model with SEED=16'hACE1 and a non-zero load.
